// File: rtl/fp_pkg.sv
// Shared single-precision float definitions: FSM encoding, field widths and canonical patterns.
// The DENORM state exists only when FP32_PACK_DENORM_EN is defined.
package fp_pkg;

   localparam int unsigned FP32_BIAS    = 127;
   localparam int unsigned FP32_EXP_MAX = 255;
   localparam int unsigned FP32_FRAC_W  = 23;
   localparam int unsigned FP32_EXP_W   = 8;
   localparam int unsigned FP32_W       = 32;

   // Magnitude patterns (everything below the sign bit).
   localparam logic [FP32_W-2:0] FP32_INF_MAG  = 31'h7F80_0000;
   localparam logic [FP32_W-2:0] FP32_ZERO_MAG = 31'h0000_0000;

`ifdef FP32_PACK_DENORM_EN
   typedef enum logic [2:0] {
      StIdle,
      StNorm,
      StRound,
      StDone,
      StDenorm
   } fp_pack_st_e;
`else
   typedef enum logic [1:0] {
      StIdle,
      StNorm,
      StRound,
      StDone
   } fp_pack_st_e;
`endif

   function automatic logic [FP32_W-1:0] fp32_assemble(
      input logic                  sign,
      input logic [FP32_EXP_W-1:0] expo,
      input logic [FP32_FRAC_W-1:0] frac
   );
      return {sign, expo, frac};
   endfunction

endpackage

// File: rtl/fp32_round_pack.sv
// Combinational round-to-nearest-even, range check and packing of a normalised magnitude.
// Tiny operands (denormal path) pack with a zero exponent field unless rounding sets the hidden bit.
module fp32_round_pack
   import fp_pkg::*;
#(
   parameter int unsigned MW = 48,
   parameter int unsigned XW = 12
) (
   input  logic          sign_i,
   input  logic [XW-1:0] exp_i,
   input  logic [MW-2:0] mant_i,
   input  logic          sticky_i,
   input  logic          tiny_i,
   output logic [31:0]   data_o,
   output logic          ovf_o,
   output logic          unf_o,
   output logic          inexact_o
);

   localparam int unsigned SigW = FP32_FRAC_W + 1;
   localparam logic [XW-1:0] ExpMax = XW'(FP32_EXP_MAX);

   logic [SigW-1:0]       sig;
   logic [SigW:0]         sig_sum;
   logic [SigW-1:0]       sig_r;
   logic [XW-1:0]         exp_r;
   logic [FP32_EXP_W-1:0] field;
   logic                  guard;
   logic                  sticky;
   logic                  inc;
   logic                  carry;
   logic                  zero;
   logic                  big;
   logic                  nonpos;

   assign sig    = mant_i[MW-2 -: SigW];
   assign guard  = mant_i[MW-26];
   assign sticky = sticky_i | (|mant_i[MW-27:0]);
   assign zero   = (mant_i == '0) && !sticky_i;

   assign inc     = guard & (sticky | sig[0]);
   assign sig_sum = {1'b0, sig} + {{SigW{1'b0}}, inc};
   assign carry   = sig_sum[SigW];
   assign sig_r   = carry ? {1'b1, {FP32_FRAC_W{1'b0}}} : sig_sum[SigW-1:0];
   assign exp_r   = exp_i + {{(XW-1){1'b0}}, carry};

   assign big    = !exp_r[XW-1] && (exp_r >= ExpMax);
   assign nonpos = exp_r[XW-1] || (exp_r == '0);
   // Hidden bit clear only happens for a tiny result that did not round up to the normal range.
   assign field  = sig_r[SigW-1] ? exp_r[FP32_EXP_W-1:0] : '0;

   always_comb begin
      data_o    = fp32_assemble(sign_i, field, sig_r[FP32_FRAC_W-1:0]);
      ovf_o     = 1'b0;
      unf_o     = 1'b0;
      inexact_o = guard | sticky;
      if (zero) begin
         data_o    = {sign_i, FP32_ZERO_MAG};
         inexact_o = 1'b0;
      end else if (big) begin
         data_o    = {sign_i, FP32_INF_MAG};
         ovf_o     = 1'b1;
         inexact_o = 1'b1;
      end else if (nonpos) begin
         data_o    = {sign_i, FP32_ZERO_MAG};
         unf_o     = 1'b1;
         inexact_o = 1'b1;
      end else begin
         unf_o = tiny_i & (guard | sticky);
      end
   end

endmodule

// File: rtl/fp32_pack.sv
// Iterative fp32 result packer: normalise one bit per cycle, round, pack, valid/ready out.
// Define FP32_PACK_DENORM_EN for gradual underflow; otherwise tiny results flush to zero.
module fp32_pack
   import fp_pkg::*;
#(
   parameter int unsigned MW = 48,
   parameter int unsigned EW = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          in_sign,
   input  logic [EW-1:0] in_exp,
   input  logic [MW-1:0] in_mant,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [31:0]   out_data,
   output logic          out_ovf,
   output logic          out_unf,
   output logic          out_inexact
);

   localparam int unsigned   XW   = EW + 2;
   localparam logic [XW-1:0] XOne = XW'(1);

   fp_pack_st_e   state_q, state_d;
   logic          sign_q, sign_d;
   logic [XW-1:0] exp_q, exp_d;
   logic [MW-1:0] mant_q, mant_d;
   logic          sticky_q, sticky_d;
   logic [31:0]   out_data_q, out_data_d;
   logic          out_ovf_q, out_ovf_d;
   logic          out_unf_q, out_unf_d;
   logic          out_inexact_q, out_inexact_d;
   logic          tiny;

   logic [31:0]   rp_data;
   logic          rp_ovf;
   logic          rp_unf;
   logic          rp_inexact;

`ifdef FP32_PACK_DENORM_EN
   localparam logic [4:0] DenormCap = 5'd26;
   logic [4:0] cnt_q, cnt_d;
   logic       tiny_q, tiny_d;
   assign tiny = tiny_q;
`else
   assign tiny = 1'b0;
`endif

   fp32_round_pack #(
      .MW (MW),
      .XW (XW)
   ) u_round_pack (
      .sign_i    (sign_q),
      .exp_i     (exp_q),
      .mant_i    (mant_q[MW-2:0]),
      .sticky_i  (sticky_q),
      .tiny_i    (tiny),
      .data_o    (rp_data),
      .ovf_o     (rp_ovf),
      .unf_o     (rp_unf),
      .inexact_o (rp_inexact)
   );

   always_comb begin
      state_d       = state_q;
      sign_d        = sign_q;
      exp_d         = exp_q;
      mant_d        = mant_q;
      sticky_d      = sticky_q;
      out_data_d    = out_data_q;
      out_ovf_d     = out_ovf_q;
      out_unf_d     = out_unf_q;
      out_inexact_d = out_inexact_q;
`ifdef FP32_PACK_DENORM_EN
      cnt_d         = cnt_q;
      tiny_d        = tiny_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               sign_d   = in_sign;
               exp_d    = {{2{in_exp[EW-1]}}, in_exp};
               mant_d   = in_mant;
               sticky_d = 1'b0;
`ifdef FP32_PACK_DENORM_EN
               cnt_d    = '0;
               tiny_d   = 1'b0;
`endif
               state_d  = StNorm;
            end
         end
         StNorm: begin
            // A nonzero magnitude needs at most MW-2 left shifts to reach bit MW-2.
            if (mant_q == '0) begin
               state_d = StRound;
            end else if (mant_q[MW-1]) begin
               mant_d   = mant_q >> 1;
               sticky_d = sticky_q | mant_q[0];
               exp_d    = exp_q + XOne;
            end else if (!mant_q[MW-2]) begin
               mant_d = mant_q << 1;
               exp_d  = exp_q - XOne;
            end else begin
`ifdef FP32_PACK_DENORM_EN
               if (exp_q[XW-1] || (exp_q == '0)) begin
                  tiny_d  = 1'b1;
                  state_d = StDenorm;
               end else begin
                  state_d = StRound;
               end
`else
               state_d = StRound;
`endif
            end
         end
`ifdef FP32_PACK_DENORM_EN
         StDenorm: begin
            mant_d   = mant_q >> 1;
            sticky_d = sticky_q | mant_q[0];
            exp_d    = exp_q + XOne;
            cnt_d    = cnt_q + 5'd1;
            if (exp_d == XOne) begin
               state_d = StRound;
            end else if (cnt_d == DenormCap) begin
               // Past the cap the whole magnitude lies below the guard bit.
               mant_d   = '0;
               sticky_d = sticky_q | (|mant_q);
               exp_d    = XOne;
               state_d  = StRound;
            end
         end
`endif
         StRound: begin
            out_data_d    = rp_data;
            out_ovf_d     = rp_ovf;
            out_unf_d     = rp_unf;
            out_inexact_d = rp_inexact;
            state_d       = StDone;
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         sign_q        <= 1'b0;
         exp_q         <= '0;
         mant_q        <= '0;
         sticky_q      <= 1'b0;
         out_data_q    <= '0;
         out_ovf_q     <= 1'b0;
         out_unf_q     <= 1'b0;
         out_inexact_q <= 1'b0;
`ifdef FP32_PACK_DENORM_EN
         cnt_q         <= '0;
         tiny_q        <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         sign_q        <= sign_d;
         exp_q         <= exp_d;
         mant_q        <= mant_d;
         sticky_q      <= sticky_d;
         out_data_q    <= out_data_d;
         out_ovf_q     <= out_ovf_d;
         out_unf_q     <= out_unf_d;
         out_inexact_q <= out_inexact_d;
`ifdef FP32_PACK_DENORM_EN
         cnt_q         <= cnt_d;
         tiny_q        <= tiny_d;
`endif
      end
   end

   assign in_ready    = (state_q == StIdle);
   assign out_valid   = (state_q == StDone);
   assign out_data    = out_data_q;
   assign out_ovf     = out_ovf_q;
   assign out_unf     = out_unf_q;
   assign out_inexact = out_inexact_q;

endmodule

// File: tb/tb_fp32_pack.sv
// Self-checking bench for fp32_pack: directed corner cases plus random operands
// checked against an arithmetic round-to-nearest-even reference model.
module tb_fp32_pack;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic        in_sign;
   logic [9:0]  in_exp;
   logic [47:0] in_mant;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_ovf;
   logic        out_unf;
   logic        out_inexact;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct packed {
      logic [31:0] data;
      logic        ovf;
      logic        unf;
      logic        inx;
      logic [31:0] lat;
   } ref_t;

   fp32_pack #(
      .MW (48),
      .EW (10)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_sign     (in_sign),
      .in_exp      (in_exp),
      .in_mant     (in_mant),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_ovf     (out_ovf),
      .out_unf     (out_unf),
      .out_inexact (out_inexact)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end else begin
         n_pass++;
      end
   endtask

   // Value = mant * 2^(exp-127-46); round the exact value to 24 significant bits.
   function automatic ref_t model(input logic s, input logic [9:0] e_in, input logic [47:0] m);
      ref_t            r;
      int              p, e, sh, k, dn;
      bit              tiny, up;
      longint unsigned mm, sig, rem, half;
      r.data = {s, 31'b0};
      r.ovf  = 1'b0;
      r.unf  = 1'b0;
      r.inx  = 1'b0;
      r.lat  = 2;
      if (m == '0) return r;
      p = 0;
      for (int i = 0; i < 48; i++) if (m[i]) p = i;
      e    = int'($signed(e_in)) + p - 46;
      k    = (p > 46) ? p - 46 : 46 - p;
      dn   = 0;
      tiny = 1'b0;
`ifdef FP32_PACK_DENORM_EN
      if (e <= 0) begin
         tiny = 1'b1;
         dn   = (1 - e > 26) ? 26 : 1 - e;
      end
`endif
      sh = p - 23 + (tiny ? 1 - e : 0);
      mm = 64'(m);
      up = 1'b0;
      if (sh <= 0) begin
         sig = mm << (-sh);
         rem = 0;
      end else if (sh > 48) begin
         sig = 0;
         rem = mm;
      end else begin
         sig  = mm >> sh;
         rem  = mm & ((64'd1 << sh) - 1);
         half = 64'd1 << (sh - 1);
         up   = (rem > half) || ((rem == half) && sig[0]);
      end
      r.inx = (rem != 0);
      if (up) sig = sig + 1;
      r.lat = 2 + k + dn;
      if (tiny) begin
         r.data = {s, (sig >= (64'd1 << 23)) ? 8'd1 : 8'd0, sig[22:0]};
         r.unf  = r.inx;
      end else begin
         if (sig == (64'd1 << 24)) begin
            sig = 64'd1 << 23;
            e   = e + 1;
         end
         if (e >= 255) begin
            r.data = {s, 31'h7F80_0000};
            r.ovf  = 1'b1;
            r.inx  = 1'b1;
         end else if (e <= 0) begin
            r.data = {s, 31'b0};
            r.unf  = 1'b1;
            r.inx  = 1'b1;
         end else begin
            r.data = {s, 8'(e), sig[22:0]};
         end
      end
      return r;
   endfunction

   task automatic run_op(input string tag, input logic s, input logic [9:0] e,
                         input logic [47:0] m, input ref_t x, input bit hold);
      int cyc;
      check_eq({tag, ".rdy"}, 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      in_sign  = s;
      in_exp   = e;
      in_mant  = m;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_sign  = 1'($urandom);
      in_exp   = 10'($urandom);
      in_mant  = {16'($urandom), 32'($urandom)};
      cyc = 0;
      while (!out_valid && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
      end
      check_eq({tag, ".lat"}, 64'(cyc), 64'(x.lat));
      check_eq({tag, ".data"}, 64'(out_data), 64'(x.data));
      check_eq({tag, ".flags"}, {61'd0, out_ovf, out_unf, out_inexact},
               {61'd0, x.ovf, x.unf, x.inx});
      if (hold) begin
         repeat (5) begin
            @(posedge clk); #1;
            check_eq({tag, ".hold_v"}, 64'(out_valid), 64'd1);
            check_eq({tag, ".hold_d"}, 64'(out_data), 64'(x.data));
            check_eq({tag, ".hold_rdy"}, 64'(in_ready), 64'd0);
         end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check_eq({tag, ".idle"}, 64'(in_ready), 64'd1);
   endtask

   function automatic ref_t mk(input logic [31:0] d, input logic o, input logic u,
                               input logic i, input int l);
      ref_t r;
      r.data = d;
      r.ovf  = o;
      r.unf  = u;
      r.inx  = i;
      r.lat  = 32'(l);
      return r;
   endfunction

   initial begin
      logic [47:0] m;
      logic [63:0] t;
      logic [9:0]  e;
      logic        s;
      ref_t        r;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_sign   = 1'b0;
      in_exp    = '0;
      in_mant   = '0;
      out_ready = 1'b0;
      #2;
      check_eq("rst.rdy", 64'(in_ready), 64'd1);
      check_eq("rst.valid", 64'(out_valid), 64'd0);
      check_eq("rst.data", 64'(out_data), 64'd0);
      check_eq("rst.flags", {61'd0, out_ovf, out_unf, out_inexact}, 64'd0);
      #10 rst_n = 1'b1;
      @(posedge clk); #1;

      run_op("one", 1'b0, 10'd127, 48'd1 << 46, mk(32'h3F80_0000, 0, 0, 0, 2), 1'b0);
      run_op("two", 1'b0, 10'd127, 48'd1 << 47, mk(32'h4000_0000, 0, 0, 0, 3), 1'b0);
      run_op("tie_even", 1'b0, 10'd127, (48'd1 << 46) | (48'd1 << 22),
             mk(32'h3F80_0000, 0, 0, 1, 2), 1'b0);
      run_op("tie_odd", 1'b0, 10'd127, (48'd1 << 46) | (48'd1 << 23) | (48'd1 << 22),
             mk(32'h3F80_0002, 0, 0, 1, 2), 1'b0);
      run_op("carry", 1'b0, 10'd127, {48{1'b1}}, mk(32'h4080_0000, 0, 0, 1, 3), 1'b0);
      run_op("ovf", 1'b0, 10'd300, 48'd1 << 46, mk(32'h7F80_0000, 1, 0, 1, 2), 1'b0);
`ifdef FP32_PACK_DENORM_EN
      run_op("tiny", 1'b0, 10'd0, 48'd1 << 46, mk(32'h0040_0000, 0, 0, 0, 3), 1'b0);
`else
      run_op("tiny", 1'b0, 10'd0, 48'd1 << 46, mk(32'h0000_0000, 0, 1, 1, 2), 1'b0);
`endif
      run_op("negzero", 1'b1, 10'd127, 48'd0, mk(32'h8000_0000, 0, 0, 0, 2), 1'b0);
      run_op("hold", 1'b0, 10'd127, 48'd1 << 46, mk(32'h3F80_0000, 0, 0, 0, 2), 1'b1);

      // Abort a long normalisation with an asynchronous reset.
      in_valid = 1'b1;
      in_sign  = 1'b0;
      in_exp   = 10'd127;
      in_mant  = 48'd1 << 26;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      check_eq("abort.valid", 64'(out_valid), 64'd0);
      check_eq("abort.rdy", 64'(in_ready), 64'd1);
      check_eq("abort.data", 64'(out_data), 64'd0);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      run_op("after_rst", 1'b0, 10'd128, 48'd3 << 45, mk(32'h4040_0000, 0, 0, 0, 2), 1'b0);

      for (int i = 0; i < 150; i++) begin
         s = 1'($urandom);
         case ($urandom_range(0, 3))
            0: e = 10'($urandom_range(100, 160));
            1: e = 10'($urandom);
            2: e = 10'(int'($urandom_range(0, 60)) - 30);
            default: e = 10'($urandom_range(230, 280));
         endcase
         t = {$urandom, $urandom};
         case ($urandom_range(0, 3))
            0: m = t[47:0];
            1: m = t[47:0] >> $urandom_range(0, 47);
            2: m = (48'd1 << 46) | (48'($urandom_range(0, 1)) << 23) | (48'd1 << 22);
            default: m = ($urandom_range(0, 7) == 0) ? 48'd0 : 48'd1 << $urandom_range(0, 47);
         endcase
         r = model(s, e, m);
         run_op($sformatf("rnd%0d", i), s, e, m, r, 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
